// File: rtl/nec_ir_decoder_if.sv
// CPU-side register interface of the NEC IR decoder: decoded frame, status flags and read acknowledge.
// The decoder drives through the master modport; the 8051 SFR side uses slave.
interface nec_ir_decoder_if;
    logic        rd_ack;
    logic [15:0] addr;
    logic [7:0]  cmd;
    logic        data_rdy;
    logic        overrun;
    logic        frame_ok;
    logic        rep;
    logic        err;
    logic        busy;

    modport master (
        input  rd_ack,
        output addr, cmd, data_rdy, overrun, frame_ok, rep, err, busy
    );

    modport slave (
        output rd_ack,
        input  addr, cmd, data_rdy, overrun, frame_ok, rep, err, busy
    );
endinterface

// File: rtl/nec_ir_decoder.sv
// NEC IR receiver: pin synchroniser, tick timebase and pulse-width FSM decoding frames and repeat codes,
// with the decoded address/command held for the CPU behind a ready/ack handshake.
module nec_ir_decoder #(
    parameter int unsigned PRESCALE = 120,
    parameter int unsigned TIMEOUT  = 1100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ir_in,
    nec_ir_decoder_if.master  bus
);
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] LEAD_MARK  = 3'd1;
    localparam logic [2:0] LEAD_SPACE = 3'd2;
    localparam logic [2:0] REP_MARK   = 3'd3;
    localparam logic [2:0] BIT_MARK   = 3'd4;
    localparam logic [2:0] BIT_SPACE  = 3'd5;

    logic          ir_s1, ir_s2, ir_d;
    logic          fall, rise, tmo;
    logic [PW-1:0] pre;
    logic [10:0]   cnt;
    logic [2:0]    state;
    logic [5:0]    bitcnt;
    logic [31:0]   sr;
    logic [15:0]   addr_q;
    logic [7:0]    cmd_q;
    logic          data_rdy_q, overrun_q, frame_ok_q, rep_q, err_q, last_ok;

    function automatic logic in_win(input logic [10:0] c, input int unsigned lo, input int unsigned hi);
        return (c >= 11'(lo)) && (c <= 11'(hi));
    endfunction

    assign fall = ir_d & ~ir_s2;
    assign rise = ~ir_d & ir_s2;
    assign tmo  = (cnt >= 11'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_s1 <= 1'b1;
            ir_s2 <= 1'b1;
            ir_d  <= 1'b1;
        end else begin
            ir_s1 <= ir_in;
            ir_s2 <= ir_s1;
            ir_d  <= ir_s2;
        end
    end

    // Timebase is held cleared in IDLE, which also covers the clear on IDLE->LEAD_MARK.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE || fall || rise) begin
            pre <= '0;
            cnt <= '0;
        end else if (pre == PW'(PRESCALE - 1)) begin
            pre <= '0;
            if (cnt != '1)
                cnt <= cnt + 11'd1;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bitcnt     <= '0;
            sr         <= '0;
            addr_q     <= '0;
            cmd_q      <= '0;
            data_rdy_q <= 1'b0;
            overrun_q  <= 1'b0;
            frame_ok_q <= 1'b0;
            rep_q      <= 1'b0;
            err_q      <= 1'b0;
            last_ok    <= 1'b0;
        end else begin
            frame_ok_q <= 1'b0;
            rep_q      <= 1'b0;
            err_q      <= 1'b0;
            if (bus.rd_ack) begin
                data_rdy_q <= 1'b0;
                overrun_q  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (fall)
                        state <= LEAD_MARK;
                end
                LEAD_MARK: begin
                    if (rise) begin
                        if (in_win(cnt, 800, 1000)) begin
                            state <= LEAD_SPACE;
                        end else begin
                            err_q <= 1'b1;
                            state <= IDLE;
                        end
                    end else if (tmo) begin
                        err_q <= 1'b1;
                        state <= IDLE;
                    end
                end
                LEAD_SPACE: begin
                    if (fall) begin
                        if (in_win(cnt, 400, 500)) begin
                            bitcnt <= '0;
                            state  <= BIT_MARK;
                        end else if (in_win(cnt, 180, 270)) begin
                            state <= REP_MARK;
                        end else begin
                            err_q <= 1'b1;
                            state <= IDLE;
                        end
                    end else if (tmo) begin
                        err_q <= 1'b1;
                        state <= IDLE;
                    end
                end
                REP_MARK: begin
                    if (rise) begin
                        if (in_win(cnt, 40, 70))
                            rep_q <= last_ok;
                        else
                            err_q <= 1'b1;
                        state <= IDLE;
                    end else if (tmo) begin
                        err_q <= 1'b1;
                        state <= IDLE;
                    end
                end
                BIT_MARK: begin
                    if (rise) begin
                        if (!in_win(cnt, 40, 70)) begin
                            err_q <= 1'b1;
                            state <= IDLE;
                        end else if (bitcnt == 6'd32) begin
                            // Completing frame overrides a same-cycle rd_ack: new data wins, overrun cleared.
                            if (sr[31:24] == ~sr[23:16]) begin
                                addr_q     <= sr[15:0];
                                cmd_q      <= sr[23:16];
                                frame_ok_q <= 1'b1;
                                data_rdy_q <= 1'b1;
                                last_ok    <= 1'b1;
                                overrun_q  <= ~bus.rd_ack & (overrun_q | data_rdy_q);
                            end else begin
                                err_q <= 1'b1;
                            end
                            state <= IDLE;
                        end else begin
                            state <= BIT_SPACE;
                        end
                    end else if (tmo) begin
                        err_q <= 1'b1;
                        state <= IDLE;
                    end
                end
                BIT_SPACE: begin
                    if (fall) begin
                        if (in_win(cnt, 40, 70)) begin
                            sr     <= {1'b0, sr[31:1]};
                            bitcnt <= bitcnt + 6'd1;
                            state  <= BIT_MARK;
                        end else if (in_win(cnt, 140, 200)) begin
                            sr     <= {1'b1, sr[31:1]};
                            bitcnt <= bitcnt + 6'd1;
                            state  <= BIT_MARK;
                        end else begin
                            err_q <= 1'b1;
                            state <= IDLE;
                        end
                    end else if (tmo) begin
                        err_q <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.addr     = addr_q;
    assign bus.cmd      = cmd_q;
    assign bus.data_rdy = data_rdy_q;
    assign bus.overrun  = overrun_q;
    assign bus.frame_ok = frame_ok_q;
    assign bus.rep      = rep_q;
    assign bus.err      = err_q;
    assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_nec_ir_decoder.sv
// Scoreboard bench for nec_ir_decoder at PRESCALE=1 (one tick per clk) to keep NEC frames short.
// Stimulus pushes the expected event; the monitor pops it when frame_ok/rep/err fires.
module tb_nec_ir_decoder;
    localparam int unsigned LMARK  = 820;
    localparam int unsigned LSPACE = 420;
    localparam int unsigned RSPACE = 220;
    localparam int unsigned BMARK  = 50;
    localparam int unsigned ZSPACE = 50;
    localparam int unsigned OSPACE = 160;

    localparam int EV_FRAME = 0;
    localparam int EV_REP   = 1;
    localparam int EV_ERR   = 2;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [7:0]  cmd;
    } ev_t;

    ev_t  sb[$];
    int   checks = 0;
    int   errors = 0;
    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic ir_in  = 1'b1;

    nec_ir_decoder_if bus();

    nec_ir_decoder #(.PRESCALE(1), .TIMEOUT(1100)) dut (
        .clk   (clk),
        .rst   (rst),
        .ir_in (ir_in),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [15:0] a, input logic [7:0] c);
        ev_t e;
        e.kind = kind;
        e.addr = a;
        e.cmd  = c;
        sb.push_back(e);
    endtask

    task automatic drive(input logic lvl, input int unsigned n);
        ir_in = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_lead_bits(input logic [31:0] w, input int unsigned nbits);
        drive(1'b0, LMARK);
        drive(1'b1, LSPACE);
        for (int unsigned i = 0; i < nbits; i++) begin
            drive(1'b0, BMARK);
            drive(1'b1, w[i] ? OSPACE : ZSPACE);
        end
    endtask

    task automatic send_repeat();
        drive(1'b0, LMARK);
        drive(1'b1, RSPACE);
        drive(1'b0, BMARK);
        drive(1'b1, 100);
    endtask

    // With ack set, rd_ack is high exactly in the cycle the final rise is consumed.
    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic ack);
        send_lead_bits({b3, b2, b1, b0}, 32);
        drive(1'b0, BMARK);
        ir_in = 1'b1;
        if (ack) begin
            @(negedge clk);
            @(negedge clk);
            bus.rd_ack = 1'b1;
            @(negedge clk);
            bus.rd_ack = 1'b0;
        end
        repeat (100) @(negedge clk);
    endtask

    always @(negedge clk) begin : monitor
        ev_t e;
        int  got;
        if (!rst && (bus.frame_ok || bus.rep || bus.err)) begin
            got = bus.frame_ok ? EV_FRAME : (bus.rep ? EV_REP : EV_ERR);
            check("pulse_onehot", 32'(bus.frame_ok) + 32'(bus.rep) + 32'(bus.err), 32'd1);
            if (sb.size() == 0) begin
                check("unexpected_event", 32'(got), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("event_kind", 32'(got), 32'(e.kind));
                check("event_addr", 32'(bus.addr), 32'(e.addr));
                check("event_cmd", 32'(bus.cmd), 32'(e.cmd));
                if (e.kind == EV_FRAME)
                    check("event_data_rdy", 32'(bus.data_rdy), 32'd1);
            end
        end
    end

    initial begin
        bus.rd_ack = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_addr", 32'(bus.addr), 32'd0);
        check("rst_cmd", 32'(bus.cmd), 32'd0);
        check("rst_flags", 32'({bus.data_rdy, bus.overrun, bus.busy, bus.frame_ok, bus.rep, bus.err}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Repeat code before any good frame: silent
        send_repeat();
        check("rep_nolast_busy", 32'(bus.busy), 32'd0);
        check("rep_nolast_rdy", 32'(bus.data_rdy), 32'd0);

        expect_ev(EV_FRAME, 16'hFB04, 8'h08);
        send_frame(8'h04, 8'hFB, 8'h08, 8'hF7, 1'b0);
        check("f1_data_rdy", 32'(bus.data_rdy), 32'd1);
        check("f1_overrun", 32'(bus.overrun), 32'd0);
        check("f1_busy", 32'(bus.busy), 32'd0);

        expect_ev(EV_REP, 16'hFB04, 8'h08);
        send_repeat();

        expect_ev(EV_ERR, 16'hFB04, 8'h08);
        send_frame(8'h22, 8'h11, 8'h08, 8'hF6, 1'b0);
        check("badchk_data_rdy", 32'(bus.data_rdy), 32'd1);

        // 5 ms leader mark
        expect_ev(EV_ERR, 16'hFB04, 8'h08);
        drive(1'b0, 500);
        drive(1'b1, 10);
        check("short_lead_busy", 32'(bus.busy), 32'd0);

        bus.rd_ack = 1'b1;
        @(negedge clk);
        bus.rd_ack = 1'b0;
        @(negedge clk);
        check("ack_data_rdy", 32'(bus.data_rdy), 32'd0);

        expect_ev(EV_FRAME, 16'hAA55, 8'h3C);
        send_frame(8'h55, 8'hAA, 8'h3C, 8'hC3, 1'b0);

        // Pin stuck low from bit-10 mark: timeout after 1100 ticks
        expect_ev(EV_ERR, 16'hAA55, 8'h3C);
        send_lead_bits(32'h0, 10);
        drive(1'b0, 1090);
        check("tmo_busy_before", 32'(bus.busy), 32'd1);
        drive(1'b0, 20);
        check("tmo_busy_after", 32'(bus.busy), 32'd0);
        drive(1'b1, 50);
        check("tmo_idle_rise", 32'(bus.busy), 32'd0);

        // data_rdy still set from 55/AA frame
        expect_ev(EV_FRAME, 16'h0201, 8'h03);
        send_frame(8'h01, 8'h02, 8'h03, 8'hFC, 1'b0);
        check("ovr_set", 32'(bus.overrun), 32'd1);
        check("ovr_data_rdy", 32'(bus.data_rdy), 32'd1);

        expect_ev(EV_FRAME, 16'hF50A, 8'h50);
        send_frame(8'h0A, 8'hF5, 8'h50, 8'hAF, 1'b1);
        check("ackwin_data_rdy", 32'(bus.data_rdy), 32'd1);
        check("ackwin_overrun", 32'(bus.overrun), 32'd0);

        send_lead_bits(32'h1234_5678, 5);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_addr", 32'(bus.addr), 32'd0);
        check("midrst_cmd", 32'(bus.cmd), 32'd0);
        check("midrst_flags", 32'({bus.data_rdy, bus.overrun, bus.busy, bus.frame_ok, bus.rep, bus.err}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // last_ok cleared by reset: repeat is silent again
        send_repeat();
        check("rep_after_rst_busy", 32'(bus.busy), 32'd0);

        expect_ev(EV_FRAME, 16'hFB04, 8'h08);
        send_frame(8'h04, 8'hFB, 8'h08, 8'hF7, 1'b0);
        check("post_rst_data_rdy", 32'(bus.data_rdy), 32'd1);
        check("post_rst_overrun", 32'(bus.overrun), 32'd0);

        repeat (20) @(negedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
